// File: rtl/oai221_sweep_checker.sv
// ---------------------------------------------------------------------------
// oai221_sweep_checker
//
// Purpose:
//   On-chip stimulus generator and response checker for OAI221 cells.
//   Steps {A,B1,B2,C1,C2} through 0..31. Each vector is held for a settle
//   window, then ZN is sampled and compared with ~(A & (B1|B2) & (C1|C2)).
//   The block counts mismatches, remembers the first failing vector and
//   reports pass/fail when the sweep finishes.
//
// Parameters:
//   SETTLE_CYC : cycles from applying a vector to sampling ZN (1..255)
//   GAP_CYC    : idle cycles after a sample before the next vector (0..255)
//
// Ports:
//   clk              in   rising-edge clock
//   rst_n            in   asynchronous active-low reset
//   start            in   sweep request (ignored while busy)
//   dut_zn           in   ZN of the cell under test
//   stim_a..stim_c2  out  cell inputs, taken from vec_idx bits 4..0
//   busy             out  sweep in progress
//   done             out  sweep complete, held until next start or reset
//   pass             out  valid with done; 1 when no mismatch was seen
//   vec_idx[4:0]     out  vector currently applied
//   sample_valid     out  one-cycle pulse per sampled vector
//   sample_zn        out  captured dut_zn, qualified by sample_valid
//   err_cnt[5:0]     out  mismatch count (0..32)
//   first_fail_valid out  at least one mismatch recorded
//   first_fail_vec   out  index of first mismatching vector
// ---------------------------------------------------------------------------
module oai221_sweep_checker #(
    parameter int unsigned SETTLE_CYC = 10,
    parameter int unsigned GAP_CYC    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_zn,
    output logic       stim_a,
    output logic       stim_b1,
    output logic       stim_b2,
    output logic       stim_c1,
    output logic       stim_c2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] vec_idx,
    output logic       sample_valid,
    output logic       sample_zn,
    output logic [5:0] err_cnt,
    output logic       first_fail_valid,
    output logic [4:0] first_fail_vec
);

    // A zero settle window would sample in the same cycle the vector changes.
    generate
        if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_bad_settle
            $error("oai221_sweep_checker: SETTLE_CYC must be in 1..255");
        end
        if (GAP_CYC > 255) begin : g_bad_gap
            $error("oai221_sweep_checker: GAP_CYC must be in 0..255");
        end
    endgenerate

    // Terminal counts for the 8-bit window counters. GAP_LAST is unused
    // when GAP_CYC is 0 because the GAP state is then skipped.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] GAP_LAST    = 8'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        GAP,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [4:0] vec_q, vec_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       sv_q, sv_d;
    logic       szn_q, szn_d;
    logic [5:0] err_q, err_d;
    logic       ffv_q, ffv_d;
    logic [4:0] ffvec_q, ffvec_d;

    logic golden_zn;
    logic mismatch;

    assign golden_zn = ~(vec_q[4] & (vec_q[3] | vec_q[2]) & (vec_q[1] | vec_q[0]));
    // Case inequality so an X/Z on the cell output is reported as a failure.
    assign mismatch  = (dut_zn !== golden_zn);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        sv_d    = 1'b0;
        szn_d   = szn_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffvec_d = ffvec_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    vec_d   = 5'd0;
                    err_d   = 6'd0;
                    ffv_d   = 1'b0;
                    ffvec_d = 5'd0;
                    pass_d  = 1'b0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = SETTLE;
                end
            end

            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            SAMPLE: begin
                sv_d  = 1'b1;
                szn_d = dut_zn;
                if (mismatch) begin
                    err_d = err_q + 6'd1;
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = vec_q;
                    end
                end
                cnt_d = 8'd0;
                if (vec_q == 5'd31) begin
                    // pass reflects the count including this last sample
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 6'd0);
                    state_d = DONE;
                end else if (GAP_CYC == 0) begin
                    vec_d   = vec_q + 5'd1;
                    state_d = SETTLE;
                end else begin
                    state_d = GAP;
                end
            end

            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 8'd0;
                    vec_d   = vec_q + 5'd1;
                    state_d = SETTLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            vec_q   <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            sv_q    <= 1'b0;
            szn_q   <= 1'b0;
            err_q   <= 6'd0;
            ffv_q   <= 1'b0;
            ffvec_q <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            sv_q    <= sv_d;
            szn_q   <= szn_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
        end
    end

    // Stimulus is the vector index itself: A is the MSB, C2 the LSB.
    assign stim_a           = vec_q[4];
    assign stim_b1          = vec_q[3];
    assign stim_b2          = vec_q[2];
    assign stim_c1          = vec_q[1];
    assign stim_c2          = vec_q[0];
    assign vec_idx          = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign sample_valid     = sv_q;
    assign sample_zn        = szn_q;
    assign err_cnt          = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

endmodule
